// File: rtl/axis_i2c_target.sv
// I2C target with AXI-Stream byte ports: oversampled SCL/SDA, START/STOP detection,
// address match with ACK, write bytes out on m_axis, read bytes in from s_axis.
package axis_i2c_pkg;
    parameter int AXIS_DATA_WIDTH = 8;
    parameter int I2C_ADDR_WIDTH  = 7;
endpackage

module axis_i2c_target #(
    parameter int AXIS_DATA_WIDTH = axis_i2c_pkg::AXIS_DATA_WIDTH,
    parameter int I2C_ADDR_WIDTH  = axis_i2c_pkg::I2C_ADDR_WIDTH,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       scl,
    input  logic                       sda_i,
    output logic                       sda_oe,
    output logic                       busy,
    output logic                       overrun,
    output logic                       underrun,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready
);

    localparam int W     = AXIS_DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD, WAIT_STOP
    } state_t;

    state_t state, state_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    logic [W-1:0]     shreg, sh_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic             rw, rw_nxt;
    logic             sda_oe_nxt, busy_nxt, ovr_nxt, udr_nxt;
    logic [W-1:0]     tdata_nxt;
    logic             tvalid_nxt;

    logic         scl_rise, scl_fall, start_det, stop_det;
    logic [W-1:0] byte_in;
    logic         addr_last, data_last, addr_match, buf_free, rd_entry;

    // Two synchronizer stages (p0, p1) followed by the history register (p2).
    // Reset to the idle bus level so leaving reset does not look like a bus event.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_i;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
    assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;

    assign byte_in    = {shreg[W-2:0], sda_p1};
    assign addr_last  = (bit_cnt == CNT_W'(I2C_ADDR_WIDTH));
    assign data_last  = (bit_cnt == CNT_W'(W - 1));
    assign addr_match = (byte_in[I2C_ADDR_WIDTH:1] == SLAVE_ADDR);
    // A byte leaving in the same cycle frees the slot for the incoming one.
    assign buf_free   = ~m_axis_tvalid | m_axis_tready;
    assign rd_entry   = ~stop_det & ~start_det & scl_fall &
                        (((state == ACK_ADDR) & sda_oe & rw) | (state == ACK_RD));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            rw            <= 1'b0;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            state         <= state_nxt;
            shreg         <= sh_nxt;
            bit_cnt       <= cnt_nxt;
            rw            <= rw_nxt;
            sda_oe        <= sda_oe_nxt;
            busy          <= busy_nxt;
            overrun       <= ovr_nxt;
            underrun      <= udr_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
        end
    end

    // STOP outranks START so a corrupted bus always falls back to IDLE.
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:     if (scl_rise && addr_last) state_nxt = addr_match ? ACK_ADDR : WAIT_STOP;
                ACK_ADDR: if (scl_fall && sda_oe)    state_nxt = rw ? READ : WRITE;
                WRITE:    if (scl_rise && data_last) state_nxt = buf_free ? ACK_WR : WAIT_STOP;
                ACK_WR:   if (scl_fall && sda_oe)    state_nxt = WRITE;
                READ:     if (scl_fall && data_last) state_nxt = ACK_RD;
                ACK_RD: begin
                    if (scl_rise && sda_p1) state_nxt = WAIT_STOP;
                    else if (scl_fall)      state_nxt = READ;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        ovr_nxt       = 1'b0;
        udr_nxt       = 1'b0;
        tdata_nxt     = m_axis_tdata;
        tvalid_nxt    = m_axis_tvalid & ~m_axis_tready;
        sh_nxt        = shreg;
        cnt_nxt       = bit_cnt;
        rw_nxt        = rw;
        s_axis_tready = 1'b0;
        if (stop_det) begin
            busy_nxt   = 1'b0;
            sda_oe_nxt = 1'b0;
        end else if (start_det) begin
            busy_nxt   = 1'b1;
            sda_oe_nxt = 1'b0;
            sh_nxt     = '0;
            cnt_nxt    = '0;
        end else if (rd_entry) begin
            s_axis_tready = rstn;
            cnt_nxt       = '0;
            if (s_axis_tvalid) begin
                sh_nxt     = s_axis_tdata;
                sda_oe_nxt = ~s_axis_tdata[W-1];
            end else begin
                sh_nxt     = '1;
                sda_oe_nxt = 1'b0;
                udr_nxt    = 1'b1;
            end
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sh_nxt = byte_in;
                        if (addr_last) begin
                            cnt_nxt = '0;
                            rw_nxt  = byte_in[0];
                        end else begin
                            cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                // First fall drives the ACK, the second releases it.
                ACK_ADDR, ACK_WR: begin
                    if (scl_fall) sda_oe_nxt = ~sda_oe;
                end
                WRITE: begin
                    if (scl_rise) begin
                        sh_nxt = byte_in;
                        if (data_last) begin
                            cnt_nxt = '0;
                            if (buf_free) begin
                                tdata_nxt  = byte_in;
                                tvalid_nxt = 1'b1;
                            end else begin
                                ovr_nxt = 1'b1;
                            end
                        end else begin
                            cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (data_last) begin
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt    = bit_cnt + CNT_W'(1);
                            sda_oe_nxt = ~shreg[W-2];
                            sh_nxt     = {shreg[W-2:0], 1'b0};
                        end
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_i2c_target.sv
// Bench for axis_i2c_target: a bit-banged I2C controller with an open-drain SDA,
// AXI-Stream monitors, and a byte-level reference model of the expected bus behaviour.
module tb_axis_i2c_target;

    localparam int Q = 10;

    logic       clk;
    logic       rstn;
    logic       scl;
    logic       m_low;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       overrun;
    logic       underrun;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;

    int n_tests;
    int n_fail;
    int ovr_cnt;
    int udr_cnt;
    int oe_cycles;
    int s_hs;
    logic [7:0] got_m[$];

    assign sda_line = ~(m_low | sda_oe);

    axis_i2c_target dut (
        .clk          (clk),
        .rstn         (rstn),
        .scl          (scl),
        .sda_i        (sda_line),
        .sda_oe       (sda_oe),
        .busy         (busy),
        .overrun      (overrun),
        .underrun     (underrun),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ovr_cnt   = 0;
        udr_cnt   = 0;
        oe_cycles = 0;
        s_hs      = 0;
    end

    always @(posedge clk) begin
        if (overrun)  ovr_cnt   <= ovr_cnt + 1;
        if (underrun) udr_cnt   <= udr_cnt + 1;
        if (sda_oe)   oe_cycles <= oe_cycles + 1;
        if (s_tready && s_tvalid) s_hs <= s_hs + 1;
        if (m_tvalid && m_tready) got_m.push_back(m_tdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        wait_q(Q); m_low = 1'b0;
        wait_q(Q); scl = 1'b1;
        wait_q(Q); m_low = 1'b1;
        wait_q(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(Q); m_low = 1'b1;
        wait_q(Q); scl = 1'b1;
        wait_q(Q); m_low = 1'b0;
        wait_q(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_q(Q); m_low = ~b;
        wait_q(Q); scl = 1'b1;
        wait_q(Q); s = sda_line;
        wait_q(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        logic [7:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
        end
        clock_bit(nack, s);
        d = v;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] exp_q[$];
        logic [7:0] wb[3];
        logic [6:0] addr;
        logic       match;
        int         nb;
        int         base_m, base_oe, base_s, base_o, base_u;

        n_tests  = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        scl      = 1'b1;
        m_low    = 1'b0;
        m_tready = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;

        wait_q(3);
        check("rst_sda_oe",   sda_oe,   0);
        check("rst_busy",     busy,     0);
        check("rst_overrun",  overrun,  0);
        check("rst_underrun", underrun, 0);
        check("rst_tvalid",   m_tvalid, 0);
        check("rst_tdata",    m_tdata,  0);
        check("rst_s_tready", s_tready, 0);
        rstn = 1'b1;
        wait_q(5);

        // Directed two-byte write
        base_m = got_m.size();
        i2c_start();
        wait_q(2);
        check("wr_busy_on", busy, 1);
        write_byte(8'hA0, ack); check("wr_ack_addr", ack, 1);
        write_byte(8'hA5, ack); check("wr_ack_b0", ack, 1);
        write_byte(8'h3C, ack); check("wr_ack_b1", ack, 1);
        i2c_stop();
        check("wr_busy_off", busy, 0);
        check("wr_count", got_m.size() - base_m, 2);
        if (got_m.size() - base_m == 2) begin
            check("wr_data0", got_m[base_m],     8'hA5);
            check("wr_data1", got_m[base_m + 1], 8'h3C);
        end

        // Directed address mismatch
        base_m  = got_m.size();
        base_oe = oe_cycles;
        i2c_start();
        write_byte(8'hA2, ack); check("mm_ack_addr", ack, 0);
        write_byte(8'h11, ack); check("mm_ack_b0", ack, 0);
        i2c_stop();
        check("mm_oe_cycles", oe_cycles - base_oe, 0);
        check("mm_count", got_m.size() - base_m, 0);

        // Randomised writes: reference model answers with ACKs and delivered bytes
        for (int t = 0; t < 4; t++) begin
            match = ($urandom_range(0, 1) == 1);
            addr  = match ? 7'h50 : 7'($urandom_range(0, 127));
            if (!match && addr == 7'h50) addr = 7'h51;
            match = (addr == 7'h50);
            nb = $urandom_range(1, 3);
            exp_q.delete();
            base_m  = got_m.size();
            base_oe = oe_cycles;
            i2c_start();
            write_byte({addr, 1'b0}, ack);
            check("rnd_ack_addr", ack, match);
            for (int i = 0; i < nb; i++) begin
                wb[i] = 8'($urandom);
                write_byte(wb[i], ack);
                check("rnd_ack_byte", ack, match);
                if (match) exp_q.push_back(wb[i]);
            end
            i2c_stop();
            check("rnd_count", got_m.size() - base_m, exp_q.size());
            if (got_m.size() - base_m == exp_q.size())
                for (int i = 0; i < exp_q.size(); i++)
                    check("rnd_data", got_m[base_m + i], exp_q[i]);
            if (!match) check("rnd_mm_oe", oe_cycles - base_oe, 0);
        end

        // Directed read: master ACKs the first byte, NACKs the second
        base_s = s_hs;
        base_u = udr_cnt;
        s_tdata  = 8'h96;
        s_tvalid = 1'b1;
        i2c_start();
        write_byte(8'hA1, ack); check("rd_ack_addr", ack, 1);
        read_byte(1'b0, rd);
        s_tdata = 8'h5A;
        check("rd_byte0", rd, 8'h96);
        read_byte(1'b1, rd);
        check("rd_byte1", rd, 8'h5A);
        wait_q(6);
        check("rd_released", sda_oe, 0);
        i2c_stop();
        check("rd_handshakes", s_hs - base_s, 2);
        check("rd_no_underrun", udr_cnt - base_u, 0);

        // Randomised read of three bytes
        base_s = s_hs;
        i2c_start();
        write_byte(8'hA1, ack); check("rrd_ack_addr", ack, 1);
        for (int i = 0; i < 3; i++) begin
            wb[i]   = 8'($urandom);
            s_tdata = wb[i];
            if (i == 0) wait_q(1);
            read_byte(i == 2, rd);
            check("rrd_byte", rd, wb[i]);
        end
        i2c_stop();
        check("rrd_handshakes", s_hs - base_s, 3);
        s_tvalid = 1'b0;

        // Overrun: buffer held full by tready=0
        m_tready = 1'b0;
        base_m = got_m.size();
        base_o = ovr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("ov_ack_addr", ack, 1);
        write_byte(8'h01, ack); check("ov_ack_b0", ack, 1);
        write_byte(8'h02, ack); check("ov_nack_b1", ack, 0);
        i2c_stop();
        check("ov_pulses", ovr_cnt - base_o, 1);
        check("ov_tdata", m_tdata, 8'h01);
        check("ov_tvalid", m_tvalid, 1);
        m_tready = 1'b1;
        wait_q(3);
        check("ov_drain_count", got_m.size() - base_m, 1);
        if (got_m.size() - base_m == 1) check("ov_drain_data", got_m[base_m], 8'h01);
        check("ov_tvalid_clr", m_tvalid, 0);

        // Underrun: read with nothing offered
        base_u = udr_cnt;
        base_s = s_hs;
        i2c_start();
        write_byte(8'hA1, ack); check("ud_ack_addr", ack, 1);
        read_byte(1'b1, rd);
        i2c_stop();
        check("ud_byte", rd, 8'hFF);
        check("ud_pulses", udr_cnt - base_u, 1);
        check("ud_handshakes", s_hs - base_s, 0);

        // Repeated START in the middle of a write byte
        base_m = got_m.size();
        wb[0]    = 8'($urandom);
        s_tdata  = wb[0];
        s_tvalid = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack); check("rs_ack_w", ack, 1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rs_ack_r", ack, 1);
        read_byte(1'b1, rd);
        i2c_stop();
        check("rs_byte", rd, wb[0]);
        check("rs_no_output", got_m.size() - base_m, 0);
        s_tvalid = 1'b0;

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(i == 0 ? 1'b0 : 1'(8'hA0 >> i), ack);
        wait_q(Q);
        check("rm_acking", sda_oe, 1);
        rstn = 1'b0;
        wait_q(1);
        check("rm_sda_oe", sda_oe, 0);
        check("rm_busy", busy, 0);
        check("rm_tvalid", m_tvalid, 0);
        check("rm_tdata", m_tdata, 0);
        check("rm_s_tready", s_tready, 0);
        rstn = 1'b1;
        wait_q(2);
        check("rm_still_off", sda_oe, 0);
        base_m = got_m.size();
        wb[0] = 8'($urandom);
        i2c_start();
        write_byte(8'hA0, ack); check("rm_ack_addr", ack, 1);
        write_byte(wb[0], ack); check("rm_ack_b0", ack, 1);
        i2c_stop();
        check("rm_count", got_m.size() - base_m, 1);
        if (got_m.size() - base_m == 1) check("rm_data", got_m[base_m], wb[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
